// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_pkg
// Brief   : Shared FPU number-format constants, divider state type, fp32 unpack
// Revision: 1.0  initial release
// ============================================================================
package fpu_pkg;

    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int QBITS = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fdiv_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic fp32_t fp32_unpack(input logic [31:0] x);
        fp32_t f;
        f.sign = x[31];
        f.exp  = x[30:23];
        f.man  = x[22:0];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_mant_step.sv
`default_nettype none
// ============================================================================
// Module  : fdiv_mant_step
// Brief   : One combinational restoring-division step (trial subtract, shift)
// Revision: 1.0  initial release
// ============================================================================
module fdiv_mant_step
    import fpu_pkg::*;
(
    input  logic [MAN_W+2:0] i_r,
    input  logic [MAN_W:0]   i_m2,
    output logic [MAN_W+2:0] o_r_next,
    output logic             o_qbit
);

    logic [MAN_W+3:0] w_diff;
    logic [MAN_W+2:0] w_keep;

    // Extra top bit of w_diff is the borrow: set means r < m2
    assign w_diff   = {1'b0, i_r} - {3'b000, i_m2};
    assign o_qbit   = ~w_diff[MAN_W+3];
    assign w_keep   = o_qbit ? w_diff[MAN_W+2:0] : i_r;
    assign o_r_next = w_keep << 1;

endmodule
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : fdiv_seq
// Brief   : Iterative binary32 divider, restoring radix-2, RNE, valid/ready
// Revision: 1.0  initial release
// ============================================================================
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        unf
);

    localparam int c_DIV_CYCLES = QBITS / STEPS_PER_CYCLE;

    fdiv_state_t             r_state;
    fdiv_state_t             w_state_nxt;
    logic                    r_sign;
    logic [MAN_W:0]          r_m2;
    logic [MAN_W+2:0]        r_rem;
    logic [QBITS-1:0]        r_q;
    logic signed [9:0]       r_eq;
    logic [4:0]              r_cnt;
    logic [31:0]             r_y;
    logic                    r_ovf;
    logic                    r_unf;

    fp32_t                   w_f1;
    fp32_t                   w_f2;
    logic                    w_sign;
    logic                    w_x1z;
    logic                    w_x2z;
    logic                    w_special;
    logic                    w_accept;
    logic [MAN_W:0]          w_m1;
    logic [MAN_W:0]          w_m2;
    logic                    w_adj;
    logic [MAN_W+2:0]        w_r0;
    logic signed [9:0]       w_eq0;
    logic                    w_last;

    assign w_f1      = fp32_unpack(x1);
    assign w_f2      = fp32_unpack(x2);
    assign w_sign    = w_f1.sign ^ w_f2.sign;
    assign w_x1z     = (w_f1.exp == '0);
    assign w_x2z     = (w_f2.exp == '0);
    assign w_special = w_x1z || w_x2z;
    assign w_accept  = in_valid && in_ready;
    assign w_m1      = {~w_x1z, w_f1.man};
    assign w_m2      = {~w_x2z, w_f2.man};

    // Pre-shift the dividend so the quotient always lands in [1,2)
    assign w_adj     = (w_m1 < w_m2);
    assign w_r0      = w_adj ? {1'b0, w_m1, 1'b0} : {2'b00, w_m1};
    assign w_eq0     = $signed({2'b00, w_f1.exp}) - $signed({2'b00, w_f2.exp})
                     + $signed(10'(BIAS)) - $signed({9'd0, w_adj});
    assign w_last    = (r_cnt == 5'(c_DIV_CYCLES - 1));

    assign in_ready  = (r_state == IDLE) && rstn;
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    // Step chain: first stage produces the most significant quotient bit
    logic [MAN_W+2:0]           w_r [STEPS_PER_CYCLE+1];
    logic [STEPS_PER_CYCLE-1:0] w_qbits;

    assign w_r[0] = r_rem;

    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        fdiv_mant_step u_step (
            .i_r      (w_r[i]),
            .i_m2     (r_m2),
            .o_r_next (w_r[i+1]),
            .o_qbit   (w_qbits[STEPS_PER_CYCLE-1-i])
        );
    end

    // Round to nearest even on the guard bit; remainder supplies the sticky
    logic              w_guard;
    logic              w_sticky;
    logic              w_up;
    logic [MAN_W:0]    w_frac_sum;
    logic              w_carry;
    logic signed [9:0] w_eq_r;

    assign w_guard    = r_q[0];
    assign w_sticky   = |r_rem;
    assign w_up       = w_guard && (w_sticky || r_q[1]);
    assign w_frac_sum = {1'b0, r_q[MAN_W:1]} + {{MAN_W{1'b0}}, w_up};
    assign w_carry    = w_frac_sum[MAN_W];
    assign w_eq_r     = r_eq + $signed({9'd0, w_carry});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : DIV;
            DIV:     if (w_last) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sign <= 1'b0;
            r_m2   <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_eq   <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_sign;
                        r_m2   <= w_m2;
                        r_rem  <= w_r0;
                        r_q    <= '0;
                        r_eq   <= w_eq0;
                        r_cnt  <= '0;
                        // Zero divisor takes priority over zero dividend
                        if (w_x2z) begin
                            r_y   <= {w_sign, 8'hFF, 23'd0};
                            r_ovf <= 1'b1;
                            r_unf <= 1'b0;
                        end else if (w_x1z) begin
                            r_y   <= {w_sign, 31'd0};
                            r_ovf <= 1'b0;
                            r_unf <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_r[STEPS_PER_CYCLE];
                    r_q   <= {r_q[QBITS-STEPS_PER_CYCLE-1:0], w_qbits};
                    r_cnt <= r_cnt + 5'd1;
                end
                ROUND: begin
                    if (w_eq_r >= 10'sd255) begin
                        r_y   <= {r_sign, 8'hFF, 23'd0};
                        r_ovf <= 1'b1;
                        r_unf <= 1'b0;
                    end else if (w_eq_r <= 10'sd0) begin
                        r_y   <= {r_sign, 31'd0};
                        r_ovf <= 1'b0;
                        r_unf <= 1'b1;
                    end else begin
                        r_y   <= {r_sign, w_eq_r[7:0], w_frac_sum[MAN_W-1:0]};
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
